alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the 64-bit ALU in the five-stage pipeline.
- Registers the decoded operands, opcode and destination info, then resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, stalls ID and inserts a bubble.
- Drives the ALU A/B/Opcode inputs.

Parameters:
- DATA_W, 64, operand/result width
- REG_AW, 5, register address width (register 0 reads as zero)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- id_valid  input  1  ID holds a real instruction
- id_opcode  input  4  ALU opcode (0000 add, 1000 sub, 0001 shl, 0100 xor, 0101 shr, 0110 or, 0111 and)
- id_rs1_addr, id_rs2_addr  input  REG_AW  source registers
- id_rs1_data, id_rs2_data  input  DATA_W  register-file read data
- id_imm  input  DATA_W  immediate
- id_use_imm  input  1  B operand takes id_imm, not rs2
- id_rd_addr  input  REG_AW  destination register
- id_reg_wr  input  1  instruction writes rd
- id_mem_rd  input  1  instruction is a load
- stall_in  input  1  downstream hold request
- flush  input  1  squash the instruction entering EX
- exmem_rd_addr  input  REG_AW;  exmem_reg_wr  input  1;  exmem_result  input  DATA_W
- memwb_rd_addr  input  REG_AW;  memwb_reg_wr  input  1;  memwb_result  input  DATA_W
- ex_valid  output  1
- ex_a, ex_b  output  DATA_W  forwarded ALU operands
- ex_opcode  output  4
- ex_rd_addr  output  REG_AW
- ex_reg_wr, ex_mem_rd  output  1
- id_stall  output  1  hold PC and IF/ID

Behaviour:
- Reset (async, immediate): all stage registers clear to 0; ex_valid=0, ex_reg_wr=0, ex_mem_rd=0, ex_opcode=0000, ex_a=ex_b=0.
- Register update priority per rising edge:
  - flush: capture bubble.
  - else stall_in: hold all registers.
  - else load_use: capture bubble.
  - else capture ID fields.
- Bubble contents: valid, reg_wr, mem_rd, operands, addrs and opcode all 0. A bubble therefore computes 0+0 with no writeback.
- load_use = ex_valid & ex_mem_rd & ex_rd_addr!=0 & id_valid & (ex_rd_addr==id_rs1_addr | (!id_use_imm & ex_rd_addr==id_rs2_addr)).
- id_stall = (load_use | stall_in) & !flush; combinational.
- Registered B equals id_imm when id_use_imm=1 (rs2 is then not forwarded); otherwise it equals id_rs2_data.
- Forwarding, combinational on the registered operands, per operand with a register source:
  - exmem_reg_wr & exmem_rd_addr==src & src!=0 selects exmem_result.
  - else memwb_reg_wr & memwb_rd_addr==src & src!=0 selects memwb_result.
  - else the registered value.
  - EX/MEM has priority over MEM/WB (youngest wins).
- Source address 0 never forwards.
- Latency: ID values appear at ex_* one cycle after capture.
- Forwarding takes effect in the same cycle as the producer's result.
- A load needs exactly one bubble; its result arrives through the MEM/WB path.
- Simultaneous flush and stall_in: flush wins and id_stall=0.

Optional Feature:
- ALU_STAGE_FWD_EN defined: forwarding as above.
- Undefined: no forwarding muxes; ex_a/ex_b are the registered values.
- Undefined: the hazard condition widens to any valid ex_reg_wr or exmem_reg_wr producer matching a nonzero ID source. Each match stalls and bubbles until the producer has left MEM, so the register file supplies the value.

Decomposition:
- Shared package: opcode constants (OP_ADD=0000, OP_SUB=1000, OP_SHL=0001, OP_XOR=0100, OP_SHR=0101, OP_OR=0110, OP_AND=0111), DATA_W, REG_AW.
- One sub-module: fwd_mux, a per-operand forwarding selector, instantiated twice.

Test Plan:
- Reset mid-stream (rst=1 while ex_valid=1) -> all outputs 0 immediately; first capture after release appears the next cycle.
- ADD r3=r1+r2 (data 5, 7), then SUB with rs1=r3 while EX/MEM holds rd=3, result 12 -> ex_a=12, not the stale register value.
- EX/MEM rd=4 result 0xAA and MEM/WB rd=4 result 0xBB, consumer reads r4 -> ex_a=0xAA. Same scenario with src r0 -> ex_a=0.
- Load to r6 followed by an OR that uses r6 -> id_stall=1 for one cycle, bubble (ex_valid=0) inserted. Next cycle ex_a=memwb_result 0x1234.
- stall_in=1 for 3 cycles -> ex_* outputs constant and id_stall=1. Add flush together with stall_in -> bubble captured and id_stall=0.
- With ALU_STAGE_FWD_EN undefined: back-to-back dependent ADDs -> two bubbles; ex_a equals the register-file data supplied after the stall.

Source files
------------

// File: rtl/alu_operand_stage_pkg.sv
// Shared widths and ALU opcode encodings for the ID/EX operand stage.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_operand_stage_pkg;

    localparam int DATA_W = 64;
    localparam int REG_AW = 5;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Per-operand bypass selector: youngest producer (EX/MEM) beats MEM/WB; r0 never forwards.
// Latency: purely combinational.
// Backpressure: none; follows whatever the pipeline registers present.
module alu_operand_stage_fwd_mux
    import alu_operand_stage_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] src_addr,
    input  logic [DW-1:0] reg_val,
    input  logic          exmem_reg_wr,
    input  logic [AW-1:0] exmem_rd_addr,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_wr,
    input  logic [AW-1:0] memwb_rd_addr,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] fwd_val
);

    // Pick the freshest copy of the source register
    always_comb begin
        fwd_val = reg_val;
        if (exmem_reg_wr && (exmem_rd_addr == src_addr) && (src_addr != '0)) begin
            fwd_val = exmem_result;
        end else if (memwb_reg_wr && (memwb_rd_addr == src_addr) && (src_addr != '0)) begin
            fwd_val = memwb_result;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register feeding the ALU, with RAW hazard handling; ALU_STAGE_FWD_EN enables bypass muxes.
// Latency: one cycle from ID capture to ex_* outputs; forwarding is same-cycle combinational.
// Backpressure: stall_in holds the stage; load-use (or any RAW without bypass) bubbles EX and raises id_stall.
module alu_operand_stage #(
    parameter int DATA_W = alu_operand_stage_pkg::DATA_W,
    parameter int REG_AW = alu_operand_stage_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [3:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_reg_wr,
    input  logic              id_mem_rd,
    input  logic              stall_in,
    input  logic              flush,
    input  logic [REG_AW-1:0] exmem_rd_addr,
    input  logic              exmem_reg_wr,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic [REG_AW-1:0] memwb_rd_addr,
    input  logic              memwb_reg_wr,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [3:0]        ex_opcode,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_wr,
    output logic              ex_mem_rd,
    output logic              id_stall
);
    import alu_operand_stage_pkg::*;

    logic              valid_q, valid_d;
    logic              reg_wr_q, reg_wr_d;
    logic              mem_rd_q, mem_rd_d;
    logic [3:0]        opcode_q, opcode_d;
    logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [REG_AW-1:0] rs1_addr_q, rs1_addr_d;
    logic [REG_AW-1:0] rs2_addr_q, rs2_addr_d;
    logic              load_use;
    logic              hazard;

    // A load in EX whose destination is needed by the instruction in ID
    always_comb begin
        load_use = valid_q & mem_rd_q & (rd_addr_q != '0) & id_valid &
                   ((rd_addr_q == id_rs1_addr) | (!id_use_imm & (rd_addr_q == id_rs2_addr)));
    end

`ifdef ALU_STAGE_FWD_EN
    // With bypass paths only a load result is too late to forward
    always_comb begin
        hazard = load_use;
    end
`else
    logic rs1_busy;
    logic rs2_busy;
    logic unused_fwd_inputs;

    // Without bypass, wait until every pending writer of a source has left MEM
    always_comb begin
        rs1_busy = (id_rs1_addr != '0) &
                   ((valid_q & reg_wr_q & (rd_addr_q == id_rs1_addr)) |
                    (exmem_reg_wr & (exmem_rd_addr == id_rs1_addr)));
        rs2_busy = !id_use_imm & (id_rs2_addr != '0) &
                   ((valid_q & reg_wr_q & (rd_addr_q == id_rs2_addr)) |
                    (exmem_reg_wr & (exmem_rd_addr == id_rs2_addr)));
        hazard   = load_use | (id_valid & (rs1_busy | rs2_busy));
    end

    assign unused_fwd_inputs = ^{exmem_result, memwb_rd_addr, memwb_reg_wr, memwb_result,
                                 rs1_addr_q, rs2_addr_q};
`endif

    // Flush overrides everything, so the front end must not hold on a flush
    always_comb begin
        id_stall = (hazard | stall_in) & !flush;
    end

    // Next stage contents: flush > hold > bubble > capture
    always_comb begin
        valid_d    = valid_q;
        reg_wr_d   = reg_wr_q;
        mem_rd_d   = mem_rd_q;
        opcode_d   = opcode_q;
        rd_addr_d  = rd_addr_q;
        a_d        = a_q;
        b_d        = b_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        if (flush || (!stall_in && hazard)) begin
            valid_d    = 1'b0;
            reg_wr_d   = 1'b0;
            mem_rd_d   = 1'b0;
            opcode_d   = '0;
            rd_addr_d  = '0;
            a_d        = '0;
            b_d        = '0;
            rs1_addr_d = '0;
            rs2_addr_d = '0;
        end else if (!stall_in) begin
            valid_d    = id_valid;
            reg_wr_d   = id_reg_wr;
            mem_rd_d   = id_mem_rd;
            opcode_d   = id_opcode;
            rd_addr_d  = id_rd_addr;
            a_d        = id_rs1_data;
            b_d        = id_use_imm ? id_imm : id_rs2_data;
            rs1_addr_d = id_rs1_addr;
            // An immediate B operand has no register source to bypass
            rs2_addr_d = id_use_imm ? '0 : id_rs2_addr;
        end
    end

    // Stage register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            reg_wr_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            opcode_q   <= OP_ADD;
            rd_addr_q  <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
        end else begin
            valid_q    <= valid_d;
            reg_wr_q   <= reg_wr_d;
            mem_rd_q   <= mem_rd_d;
            opcode_q   <= opcode_d;
            rd_addr_q  <= rd_addr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
        end
    end

`ifdef ALU_STAGE_FWD_EN
    alu_operand_stage_fwd_mux #(.DW(DATA_W), .AW(REG_AW)) u_fwd_a (
        .src_addr      (rs1_addr_q),
        .reg_val       (a_q),
        .exmem_reg_wr  (exmem_reg_wr),
        .exmem_rd_addr (exmem_rd_addr),
        .exmem_result  (exmem_result),
        .memwb_reg_wr  (memwb_reg_wr),
        .memwb_rd_addr (memwb_rd_addr),
        .memwb_result  (memwb_result),
        .fwd_val       (ex_a)
    );

    alu_operand_stage_fwd_mux #(.DW(DATA_W), .AW(REG_AW)) u_fwd_b (
        .src_addr      (rs2_addr_q),
        .reg_val       (b_q),
        .exmem_reg_wr  (exmem_reg_wr),
        .exmem_rd_addr (exmem_rd_addr),
        .exmem_result  (exmem_result),
        .memwb_reg_wr  (memwb_reg_wr),
        .memwb_rd_addr (memwb_rd_addr),
        .memwb_result  (memwb_result),
        .fwd_val       (ex_b)
    );
`else
    assign ex_a = a_q;
    assign ex_b = b_q;
`endif

    assign ex_valid   = valid_q;
    assign ex_opcode  = opcode_q;
    assign ex_rd_addr = rd_addr_q;
    assign ex_reg_wr  = reg_wr_q;
    assign ex_mem_rd  = mem_rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage (default build and ALU_STAGE_FWD_EN build).
// Expected EX contents are queued as ID stimulus is driven and popped one cycle later.
// id_stall is checked combinationally in the cycle the stimulus is presented.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        reg_wr;
        logic        mem_rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use_imm, id_reg_wr, id_mem_rd, stall_in, flush;
    logic [3:0]  id_opcode;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [63:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  exmem_rd_addr, memwb_rd_addr;
    logic        exmem_reg_wr, memwb_reg_wr;
    logic [63:0] exmem_result, memwb_result;
    logic        ex_valid, ex_reg_wr, ex_mem_rd, id_stall;
    logic [63:0] ex_a, ex_b;
    logic [3:0]  ex_opcode;
    logic [4:0]  ex_rd_addr;

    exp_t sb[$];
    exp_t e, obs;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_rd_addr(id_rd_addr), .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd),
        .stall_in(stall_in), .flush(flush),
        .exmem_rd_addr(exmem_rd_addr), .exmem_reg_wr(exmem_reg_wr), .exmem_result(exmem_result),
        .memwb_rd_addr(memwb_rd_addr), .memwb_reg_wr(memwb_reg_wr), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_opcode(ex_opcode),
        .ex_rd_addr(ex_rd_addr), .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd),
        .id_stall(id_stall)
    );

    function automatic exp_t mk(logic v, logic [63:0] a, logic [63:0] b, logic [3:0] op,
                                logic [4:0] rd, logic wr, logic mr);
        exp_t r;
        r.valid = v; r.a = a; r.b = b; r.op = op; r.rd = rd; r.reg_wr = wr; r.mem_rd = mr;
        return r;
    endfunction

    function automatic exp_t cur();
        return mk(ex_valid, ex_a, ex_b, ex_opcode, ex_rd_addr, ex_reg_wr, ex_mem_rd);
    endfunction

    task automatic set_id(logic v, logic [3:0] op, logic [4:0] rs1, logic [63:0] d1,
                          logic [4:0] rs2, logic [63:0] d2, logic [63:0] imm, logic ui,
                          logic [4:0] rd, logic wr, logic mr);
        id_valid = v; id_opcode = op; id_rs1_addr = rs1; id_rs1_data = d1;
        id_rs2_addr = rs2; id_rs2_data = d2; id_imm = imm; id_use_imm = ui;
        id_rd_addr = rd; id_reg_wr = wr; id_mem_rd = mr;
    endtask

    task automatic idle_id();
        set_id(1'b0, OP_ADD, 5'd0, 64'd0, 5'd0, 64'd0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic set_exmem(logic [4:0] rd, logic wr, logic [63:0] res);
        exmem_rd_addr = rd; exmem_reg_wr = wr; exmem_result = res;
    endtask

    task automatic set_memwb(logic [4:0] rd, logic wr, logic [63:0] res);
        memwb_rd_addr = rd; memwb_reg_wr = wr; memwb_result = res;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles();
        idle_id(); set_exmem(5'd0, 1'b0, 64'd0); set_memwb(5'd0, 1'b0, 64'd0);
        stall_in = 1'b0; flush = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
        idle_id(); set_exmem(5'd0, 1'b0, 64'd0); set_memwb(5'd0, 1'b0, 64'd0);
        #2;
        obs = cur(); n_checks++;
        if (obs !== '0) begin n_fail++; $display("FAIL reset_state: got %h expected 0", obs); end
        n_checks++;
        if (id_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", id_stall); end
        rst = 1'b0;
        set_id(1'b1, OP_ADD, 5'd1, 64'd5, 5'd2, 64'd7, 64'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        sb.push_back(mk(1'b1, 64'd5, 64'd7, OP_ADD, 5'd3, 1'b1, 1'b0));
        tick();
        obs = cur(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL first_capture: got %h expected %h", obs, e); end
        rst = 1'b1;
        #1;
        obs = cur(); n_checks++;
        if (obs !== '0) begin n_fail++; $display("FAIL async_reset: got %h expected 0", obs); end
        rst = 1'b0;
        set_id(1'b1, OP_AND, 5'd8, 64'h3C, 5'd9, 64'hF0, 64'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        sb.push_back(mk(1'b1, 64'h3C, 64'hF0, OP_AND, 5'd10, 1'b1, 1'b0));
        tick();
        obs = cur(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL post_reset_capture: got %h expected %h", obs, e); end
    endtask

    task automatic test_immediate();
        idle_cycles();
        set_exmem(5'd3, 1'b1, 64'hEE);
        set_id(1'b1, OP_SHL, 5'd1, 64'd5, 5'd3, 64'h999, 64'h40, 1'b1, 5'd10, 1'b1, 1'b0);
        sb.push_back(mk(1'b1, 64'd5, 64'h40, OP_SHL, 5'd10, 1'b1, 1'b0));
        #1; n_checks++;
        if (id_stall !== 1'b0) begin n_fail++; $display("FAIL imm_no_stall: got %b expected 0", id_stall); end
        tick();
        idle_id();
        #1;
        obs = cur(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL imm_operand: got %h expected %h", obs, e); end
        set_exmem(5'd0, 1'b0, 64'd0);
    endtask

    task automatic test_load_use();
        idle_cycles();
        set_id(1'b1, OP_ADD, 5'd1, 64'h100, 5'd0, 64'd0, 64'h8, 1'b1, 5'd6, 1'b1, 1'b1);
        sb.push_back(mk(1'b1, 64'h100, 64'h8, OP_ADD, 5'd6, 1'b1, 1'b1));
        #1; n_checks++;
        if (id_stall !== 1'b0) begin n_fail++; $display("FAIL load_issue_stall: got %b expected 0", id_stall); end
        tick();
        set_id(1'b1, OP_OR, 5'd6, 64'h55, 5'd2, 64'h0F, 64'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        #1;
        obs = cur(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL load_in_ex: got %h expected %h", obs, e); end
        n_checks++;
        if (id_stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall: got %b expected 1", id_stall); end
        sb.push_back('0);
        tick();
        set_exmem(5'd6, 1'b1, 64'hDEAD);
`ifdef ALU_STAGE_FWD_EN
        #1;
        obs = cur(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL load_bubble: got %h expected %h", obs, e); end
        n_checks++;
        if (id_stall !== 1'b0) begin n_fail++; $display("FAIL load_release: got %b expected 0", id_stall); end
        sb.push_back(mk(1'b1, 64'h1234, 64'h0F, OP_OR, 5'd7, 1'b1, 1'b0));
        tick();
        set_exmem(5'd0, 1'b0, 64'd0); set_memwb(5'd6, 1'b1, 64'h1234); idle_id();
`else
        #1;
        obs = cur(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL load_bubble: got %h expected %h", obs, e); end
        n_checks++;
        if (id_stall !== 1'b1) begin n_fail++; $display("FAIL load_exmem_stall: got %b expected 1", id_stall); end
        sb.push_back('0);
        tick();
        set_exmem(5'd0, 1'b0, 64'd0); set_memwb(5'd6, 1'b1, 64'h1234);
        set_id(1'b1, OP_OR, 5'd6, 64'h1234, 5'd2, 64'h0F, 64'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        #1;
        obs = cur(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL load_bubble2: got %h expected %h", obs, e); end
        n_checks++;
        if (id_stall !== 1'b0) begin n_fail++; $display("FAIL load_release: got %b expected 0", id_stall); end
        sb.push_back(mk(1'b1, 64'h1234, 64'h0F, OP_OR, 5'd7, 1'b1, 1'b0));
        tick();
        set_memwb(5'd0, 1'b0, 64'd0); idle_id();
`endif
        #1;
        obs = cur(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL load_consumer: got %h expected %h", obs, e); end
        set_memwb(5'd0, 1'b0, 64'd0);
    endtask

    task automatic test_stall_flush();
        idle_cycles();
        set_id(1'b1, OP_XOR, 5'd1, 64'hF0, 5'd2, 64'h0F, 64'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        e = mk(1'b1, 64'hF0, 64'h0F, OP_XOR, 5'd8, 1'b1, 1'b0);
        sb.push_back(e);
        tick();
        stall_in = 1'b1;
        set_id(1'b1, OP_AND, 5'd1, 64'h1, 5'd2, 64'h2, 64'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        #1;
        obs = cur(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL stall_pre: got %h expected %h", obs, e); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (id_stall !== 1'b1) begin n_fail++; $display("FAIL stall_id_stall[%0d]: got %b expected 1", i, id_stall); end
            sb.push_back(e);
            tick(); #1;
            obs = cur(); e = sb.pop_front(); n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs, e); end
        end
        flush = 1'b1;
        #1; n_checks++;
        if (id_stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", id_stall); end
        sb.push_back('0);
        tick();
        flush = 1'b0; stall_in = 1'b0; idle_id();
        #1;
        obs = cur(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL flush_bubble: got %h expected %h", obs, e); end
    endtask

`ifdef ALU_STAGE_FWD_EN
    task automatic test_forwarding();
        idle_cycles();
        set_id(1'b1, OP_ADD, 5'd1, 64'd5, 5'd2, 64'd7, 64'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        sb.push_back(mk(1'b1, 64'd5, 64'd7, OP_ADD, 5'd3, 1'b1, 1'b0));
        tick();
        set_id(1'b1, OP_SUB, 5'd3, 64'h77, 5'd2, 64'd7, 64'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        #1;
        obs = cur(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL fwd_producer: got %h expected %h", obs, e); end
        n_checks++;
        if (id_stall !== 1'b0) begin n_fail++; $display("FAIL fwd_no_stall: got %b expected 0", id_stall); end
        sb.push_back(mk(1'b1, 64'd12, 64'd7, OP_SUB, 5'd5, 1'b1, 1'b0));
        tick();
        set_exmem(5'd3, 1'b1, 64'd12);
        set_id(1'b1, OP_XOR, 5'd4, 64'h11, 5'd5, 64'h33, 64'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        #1;
        obs = cur(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL fwd_exmem: got %h expected %h", obs, e); end
        sb.push_back(mk(1'b1, 64'hAA, 64'h33, OP_XOR, 5'd9, 1'b1, 1'b0));
        tick();
        set_exmem(5'd4, 1'b1, 64'hAA); set_memwb(5'd4, 1'b1, 64'hBB);
        set_id(1'b1, OP_SHR, 5'd0, 64'd0, 5'd4, 64'h44, 64'd0, 1'b0, 5'd11, 1'b1, 1'b0);
        #1;
        obs = cur(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL fwd_priority: got %h expected %h", obs, e); end
        sb.push_back(mk(1'b1, 64'd0, 64'hBB, OP_SHR, 5'd11, 1'b1, 1'b0));
        tick();
        set_exmem(5'd0, 1'b1, 64'hAA); set_memwb(5'd4, 1'b1, 64'hBB); idle_id();
        #1;
        obs = cur(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL fwd_r0_memwb: got %h expected %h", obs, e); end
        set_exmem(5'd0, 1'b0, 64'd0); set_memwb(5'd0, 1'b0, 64'd0);
    endtask
`else
    task automatic test_back_to_back();
        idle_cycles();
        set_id(1'b1, OP_ADD, 5'd1, 64'd5, 5'd2, 64'd7, 64'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        sb.push_back(mk(1'b1, 64'd5, 64'd7, OP_ADD, 5'd3, 1'b1, 1'b0));
        #1; n_checks++;
        if (id_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_first_stall: got %b expected 0", id_stall); end
        tick();
        set_id(1'b1, OP_ADD, 5'd3, 64'h99, 5'd1, 64'd5, 64'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        #1;
        obs = cur(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL b2b_producer: got %h expected %h", obs, e); end
        n_checks++;
        if (id_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_ex: got %b expected 1", id_stall); end
        sb.push_back('0);
        tick();
        set_exmem(5'd3, 1'b1, 64'd12);
        #1;
        obs = cur(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL b2b_bubble1: got %h expected %h", obs, e); end
        n_checks++;
        if (id_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_mem: got %b expected 1", id_stall); end
        sb.push_back('0);
        tick();
        set_exmem(5'd0, 1'b0, 64'd0); set_memwb(5'd3, 1'b1, 64'd12);
        set_id(1'b1, OP_ADD, 5'd3, 64'd12, 5'd1, 64'd5, 64'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        #1;
        obs = cur(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL b2b_bubble2: got %h expected %h", obs, e); end
        n_checks++;
        if (id_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_release: got %b expected 0", id_stall); end
        sb.push_back(mk(1'b1, 64'd12, 64'd5, OP_ADD, 5'd4, 1'b1, 1'b0));
        tick();
        set_memwb(5'd0, 1'b0, 64'd0);
        set_exmem(5'd0, 1'b1, 64'hAA);
        set_id(1'b1, OP_SUB, 5'd0, 64'd0, 5'd2, 64'd7, 64'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        #1;
        obs = cur(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL b2b_consumer: got %h expected %h", obs, e); end
        n_checks++;
        if (id_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_r0_no_stall: got %b expected 0", id_stall); end
        sb.push_back(mk(1'b1, 64'd0, 64'd7, OP_SUB, 5'd0, 1'b1, 1'b0));
        tick();
        set_exmem(5'd0, 1'b0, 64'd0); idle_id();
        #1;
        obs = cur(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL b2b_r0_capture: got %h expected %h", obs, e); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_immediate();
        test_load_use();
        test_stall_flush();
`ifdef ALU_STAGE_FWD_EN
        test_forwarding();
`else
        test_back_to_back();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
